ps2_keypad: RTL and testbench

Synchronous PS/2 scan-code to CHIP-8 hex-keypad decoder that replaces the top-level keyboard event logic. It sits between the `ps2in` receiver and the CPU and runs on the CPU-side clock. It tracks scan-code set 2 make/break sequences, including `E0` extended sequences, and presents a 16-bit key matrix. It also buffers key-press events in a FIFO so the CPU can service FX0A (wait for key) without missing short presses.

---
 rtl/ps2_keypad_if.sv | 27 ++
 rtl/ps2_keypad.sv | 155 +++++++++++++++
 tb/tb_ps2_keypad.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_keypad_if.sv
// ps2_keypad_if: scan-code input, key matrix and press-event FIFO signals
// between the PS/2 receiver/CPU side and the keypad decoder.
`default_nettype none

interface ps2_keypad_if;
  logic        code_valid;
  logic [7:0]  code;
  logic [15:0] key_matrix;
  logic        any_key;
  logic        evt_valid;
  logic [3:0]  evt_key;
  logic        evt_pop;
  logic        evt_flush;
  logic        overflow;

  modport master (
    output code_valid, code, evt_pop, evt_flush,
    input  key_matrix, any_key, evt_valid, evt_key, overflow
  );

  modport slave (
    input  code_valid, code, evt_pop, evt_flush,
    output key_matrix, any_key, evt_valid, evt_key, overflow
  );
endinterface

`default_nettype wire

// File: rtl/ps2_keypad.sv
// ps2_keypad: PS/2 set-2 make/break parser driving a CHIP-8 hex key matrix
// plus a press-event FIFO.  Revision 1.0
`default_nettype none

module ps2_keypad #(
  parameter int LAYOUT     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         res_n,
  ps2_keypad_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] c_depth = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [15:0]  matrix_q, matrix_d;
  logic         any_key_q;
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         ovf_q, ovf_d;
  logic [3:0]   mem_q [FIFO_DEPTH];

  logic         make_ev, brk_ev, hotplug;
  logic         hit;
  logic [3:0]   key;
  logic         push, pop, do_write, empty, full;

  // Returns {hit, key}; hit=0 for codes with no keypad position.
  function automatic logic [4:0] map_code(input logic [7:0] c);
    logic [4:0] r;
    r = 5'h00;
    if (LAYOUT == 0) begin
      case (c)
        8'h16: r = 5'h11;  8'h1E: r = 5'h12;  8'h26: r = 5'h13;  8'h25: r = 5'h1C;
        8'h15: r = 5'h14;  8'h1D: r = 5'h15;  8'h24: r = 5'h16;  8'h2D: r = 5'h1D;
        8'h1C: r = 5'h17;  8'h1B: r = 5'h18;  8'h23: r = 5'h19;  8'h2B: r = 5'h1E;
        8'h1A: r = 5'h1A;  8'h22: r = 5'h10;  8'h21: r = 5'h1B;  8'h2A: r = 5'h1F;
        default: r = 5'h00;
      endcase
    end else begin
      case (c)
        8'h45: r = 5'h10;  8'h16: r = 5'h11;  8'h1E: r = 5'h12;  8'h26: r = 5'h13;
        8'h25: r = 5'h14;  8'h2E: r = 5'h15;  8'h36: r = 5'h16;  8'h3D: r = 5'h17;
        8'h3E: r = 5'h18;  8'h46: r = 5'h19;  8'h1C: r = 5'h1A;  8'h32: r = 5'h1B;
        8'h21: r = 5'h1C;  8'h23: r = 5'h1D;  8'h24: r = 5'h1E;  8'h2B: r = 5'h1F;
        default: r = 5'h00;
      endcase
    end
    return r;
  endfunction

  assign {hit, key} = map_code(bus.code);

  always_comb begin
    state_d = state_q;
    make_ev = 1'b0;
    brk_ev  = 1'b0;
    hotplug = 1'b0;
    if (bus.code_valid) begin
      case (state_q)
        IDLE: begin
          case (bus.code)
            8'hF0:                               state_d = BRK;
            8'hE0:                               state_d = EXT;
            8'hAA:                               hotplug = 1'b1;
            8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF:   state_d = IDLE;
            default:                             make_ev = 1'b1;
          endcase
        end
        BRK: begin
          brk_ev  = 1'b1;
          state_d = IDLE;
        end
        EXT:     state_d = (bus.code == 8'hF0) ? EXT_BRK : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Typematic repeats arrive as makes on an already-held key: no new event.
  always_comb begin
    matrix_d = matrix_q;
    push     = 1'b0;
    if (hotplug) begin
      matrix_d = 16'h0000;
    end else if (make_ev && hit && !matrix_q[key]) begin
      matrix_d[key] = 1'b1;
      push          = 1'b1;
    end else if (brk_ev && hit) begin
      matrix_d[key] = 1'b0;
    end
  end

  assign empty    = (wr_q == rd_q);
  assign full     = ((wr_q - rd_q) == c_depth);
  assign pop      = bus.evt_pop && !empty;
  assign do_write = push && !bus.evt_flush && (!full || pop);

  always_comb begin
    wr_d  = wr_q + (AW+1)'(do_write);
    rd_d  = rd_q + (AW+1)'(pop);
    ovf_d = ovf_q;
    if (bus.evt_flush) begin
      wr_d  = '0;
      rd_d  = '0;
      ovf_d = 1'b0;
    end else if (push && full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q   <= IDLE;
      matrix_q  <= 16'h0000;
      any_key_q <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      matrix_q  <= matrix_d;
      any_key_q <= |matrix_q;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage is cleared on reset so evt_key reads 0 out of reset.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 4'h0;
    end else if (do_write) begin
      mem_q[wr_q[AW-1:0]] <= key;
    end
  end

  assign bus.key_matrix = matrix_q;
  assign bus.any_key    = any_key_q;
  assign bus.evt_valid  = !empty;
  assign bus.evt_key    = mem_q[rd_q[AW-1:0]];
  assign bus.overflow   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_keypad.sv
// tb_ps2_keypad: directed self-checking bench for ps2_keypad, both layouts
// driven from one shared stimulus.
`default_nettype none

module tb_ps2_keypad;

  logic       clk = 1'b0;
  logic       res_n;
  logic       cv;
  logic [7:0] code;
  logic       pop;
  logic       flush;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ps2_keypad_if if0 ();
  ps2_keypad_if if1 ();

  assign if0.code_valid = cv;
  assign if0.code       = code;
  assign if0.evt_pop    = pop;
  assign if0.evt_flush  = flush;
  assign if1.code_valid = cv;
  assign if1.code       = code;
  assign if1.evt_pop    = pop;
  assign if1.evt_flush  = flush;

  ps2_keypad #(.LAYOUT(0), .FIFO_DEPTH(4)) u_dut0 (
    .clk   (clk),
    .res_n (res_n),
    .bus   (if0.slave)
  );

  ps2_keypad #(.LAYOUT(1), .FIFO_DEPTH(4)) u_dut1 (
    .clk   (clk),
    .res_n (res_n),
    .bus   (if1.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consecutive calls produce back-to-back strobes.
  task automatic send(input logic [7:0] b);
    cv   = 1'b1;
    code = b;
    tick();
    cv   = 1'b0;
  endtask

  task automatic pop_one();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic do_reset();
    res_n = 1'b0;
    cv    = 1'b0;
    tick();
    res_n = 1'b1;
  endtask

  initial begin
    res_n = 1'b0; cv = 1'b0; code = 8'h00; pop = 1'b0; flush = 1'b0;
    tick();
    tick();
    res_n = 1'b1;
    check("rst_matrix", 32'(if0.key_matrix), 32'h0);
    check("rst_any",    32'(if0.any_key),    32'h0);
    check("rst_valid",  32'(if0.evt_valid),  32'h0);
    check("rst_key",    32'(if0.evt_key),    32'h0);
    check("rst_ovf",    32'(if0.overflow),   32'h0);

    // Basic press / release
    send(8'h1C);
    check("press_matrix", 32'(if0.key_matrix), 32'h0080);
    check("press_valid",  32'(if0.evt_valid),  32'h1);
    check("press_key",    32'(if0.evt_key),    32'h7);
    check("press_any_lag", 32'(if0.any_key),   32'h0);
    tick();
    check("press_any",    32'(if0.any_key),    32'h1);
    send(8'hF0); send(8'h1C);
    check("rel_matrix",   32'(if0.key_matrix), 32'h0000);
    check("rel_valid",    32'(if0.evt_valid),  32'h1);
    check("rel_key",      32'(if0.evt_key),    32'h7);
    pop_one();
    check("rel_pop_empty", 32'(if0.evt_valid), 32'h0);

    // Typematic repeat
    send(8'h1A); send(8'h1A); send(8'h1A);
    check("rep_matrix", 32'(if0.key_matrix), 32'h0400);
    check("rep_key",    32'(if0.evt_key),    32'hA);
    pop_one();
    check("rep_one_entry", 32'(if0.evt_valid), 32'h0);
    send(8'hF0); send(8'h1A);
    check("rep_rel_matrix", 32'(if0.key_matrix), 32'h0000);
    check("rep_rel_valid",  32'(if0.evt_valid),  32'h0);

    // Extended sequences are filtered
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    check("ext_matrix", 32'(if0.key_matrix), 32'h0000);
    check("ext_valid",  32'(if0.evt_valid),  32'h0);
    send(8'h16);
    check("ext_idle_matrix", 32'(if0.key_matrix), 32'h0002);
    check("ext_idle_key",    32'(if0.evt_key),    32'h1);

    // Overflow with depth 4
    do_reset();
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
    check("ovf_not_yet", 32'(if0.overflow), 32'h0);
    send(8'h15);
    check("ovf_set",    32'(if0.overflow),   32'h1);
    check("ovf_matrix", 32'(if0.key_matrix), 32'h101E);
    check("ovf_head1",  32'(if0.evt_key),    32'h1);
    pop = 1'b1;
    tick(); check("ovf_head2", 32'(if0.evt_key), 32'h2);
    tick(); check("ovf_head3", 32'(if0.evt_key), 32'h3);
    tick(); check("ovf_head4", 32'(if0.evt_key), 32'hC);
    tick(); check("ovf_drained", 32'(if0.evt_valid), 32'h0);
    pop = 1'b0;
    check("ovf_sticky", 32'(if0.overflow), 32'h1);
    flush = 1'b1; tick(); flush = 1'b0;
    check("ovf_flushed", 32'(if0.overflow), 32'h0);

    // Pop and push together while full
    do_reset();
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
    pop = 1'b1;
    send(8'h15);
    pop = 1'b0;
    check("fullpp_ovf",  32'(if0.overflow), 32'h0);
    check("fullpp_head", 32'(if0.evt_key),  32'h2);
    pop = 1'b1;
    tick(); check("fullpp_h3", 32'(if0.evt_key), 32'h3);
    tick(); check("fullpp_hC", 32'(if0.evt_key), 32'hC);
    tick(); check("fullpp_h4", 32'(if0.evt_key), 32'h4);
    tick(); check("fullpp_empty", 32'(if0.evt_valid), 32'h0);
    pop = 1'b0;

    // Literal hex layout and hot-plug
    do_reset();
    send(8'h45); send(8'h2B);
    check("l1_matrix", 32'(if1.key_matrix), 32'h8001);
    check("l1_head",   32'(if1.evt_key),    32'h0);
    send(8'hAA);
    check("hp_matrix", 32'(if1.key_matrix), 32'h0000);
    check("hp_valid",  32'(if1.evt_valid),  32'h1);
    check("hp_head0",  32'(if1.evt_key),    32'h0);
    pop_one();
    check("hp_headF",  32'(if1.evt_key),    32'hF);
    pop_one();
    check("hp_empty",  32'(if1.evt_valid),  32'h0);

    // Reset in the middle of a break sequence
    do_reset();
    send(8'h15);
    check("mid_press", 32'(if0.key_matrix), 32'h0010);
    send(8'hF0);
    do_reset();
    check("mid_rst_matrix", 32'(if0.key_matrix), 32'h0);
    check("mid_rst_valid",  32'(if0.evt_valid),  32'h0);
    check("mid_rst_any",    32'(if0.any_key),    32'h0);
    check("mid_rst_key",    32'(if0.evt_key),    32'h0);
    send(8'h15);
    check("mid_make_matrix", 32'(if0.key_matrix), 32'h0010);
    check("mid_make_valid",  32'(if0.evt_valid),  32'h1);
    check("mid_make_key",    32'(if0.evt_key),    32'h4);

    // Flush wins over a same-cycle push
    do_reset();
    flush = 1'b1;
    send(8'h1C);
    flush = 1'b0;
    check("fp_valid",  32'(if0.evt_valid),  32'h0);
    check("fp_matrix", 32'(if0.key_matrix), 32'h0080);
    check("fp_ovf",    32'(if0.overflow),   32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
